controle_display: RTL and testbench

Sequential binary-to-BCD controller for the board's seven-segment display bank. It captures an unsigned binary value from the processor datapath and converts it with a shift-and-add-3 (double-dabble) sequence, one bit per clock. It then presents a stable, optionally zero-blanked set of BCD nibbles to the per-digit BCD-to-seven-segment decoders. Those decoders render any nibble above 9 as a dark digit, so this block uses 4'hF as its "blank" code.

---
 rtl/controle_display.sv | 103 ++++++++++
 tb/tb_controle_display.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_display.sv
// Sequential double-dabble binary-to-BCD converter that drives the seven-segment display bank.
// Result appears LARGURA+1 cycles after capture; carregar is ignored while busy, and 4'hF marks a dark digit.
module controle_display #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [LARGURA-1:0]     valor,
  input  logic                   carregar,
  input  logic                   apagar_zeros,
  output logic [4*DIGITOS-1:0]   bcd_saida,
  output logic                   ocupado,
  output logic                   pronto
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam int AW = 4 * DIGITOS;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    FINAL
  } estado_t;

  estado_t           estado;
  logic [LARGURA-1:0] desloc;
  logic [AW-1:0]     acum;
  logic [AW-1:0]     acum_aj;
  logic [AW-1:0]     acum_apag;
  logic [CW-1:0]     cont;
  logic              apag_reg;
  logic              lider;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    acum_aj = acum;
    for (int i = 0; i < DIGITOS; i++) begin
      if (acum[4*i +: 4] >= 4'd5) begin
        acum_aj[4*i +: 4] = acum[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking; digit 0 always stays visible so zero shows as "0".
  always_comb begin
    acum_apag = acum;
    lider     = apag_reg;
    for (int i = DIGITOS - 1; i >= 1; i--) begin
      if (lider && (acum[4*i +: 4] == 4'd0)) begin
        acum_apag[4*i +: 4] = 4'hF;
      end else begin
        lider = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      desloc    <= '0;
      acum      <= '0;
      cont      <= '0;
      apag_reg  <= 1'b0;
      bcd_saida <= '1;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (carregar) begin
            desloc   <= valor;
            acum     <= '0;
            cont     <= CW'(LARGURA);
            apag_reg <= apagar_zeros;
            ocupado  <= 1'b1;
            estado   <= CONVERTE;
          end
        end
        CONVERTE: begin
          acum   <= {acum_aj[AW-2:0], desloc[LARGURA-1]};
          desloc <= {desloc[LARGURA-2:0], 1'b0};
          cont   <= cont - CW'(1);
          if (cont == CW'(1)) begin
            estado <= FINAL;
          end
        end
        FINAL: begin
          bcd_saida <= acum_apag;
          pronto    <= 1'b1;
          ocupado   <= 1'b0;
          estado    <= OCIOSO;
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_display.sv
// Directed bench for controle_display at default parameters (16-bit input, 5 digits).
module tb_controle_display;

  logic        clock;
  logic        reset_n;
  logic [15:0] valor;
  logic        carregar;
  logic        apagar_zeros;
  logic [19:0] bcd_saida;
  logic        ocupado;
  logic        pronto;

  int vetores;
  int erros;

  controle_display #(.LARGURA(16), .DIGITOS(5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valor       (valor),
    .carregar    (carregar),
    .apagar_zeros(apagar_zeros),
    .bcd_saida   (bcd_saida),
    .ocupado     (ocupado),
    .pronto      (pronto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runs one conversion; inputs are scrambled after capture to prove they were latched.
  // ciclos = edges from capture to pronto (-1 on timeout), ocup = cycles ocupado was high.
  task automatic converter(input logic [15:0] v, input logic az,
                           output int ciclos, output int ocup, output logic [19:0] res);
    ciclos = -1;
    ocup   = 0;
    res    = 'x;
    @(negedge clock);
    valor        = v;
    apagar_zeros = az;
    carregar     = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 1) begin
        carregar     = 1'b0;
        valor        = ~v;
        apagar_zeros = ~az;
      end
      if (ocupado) ocup++;
      if (pronto) begin
        ciclos = c - 1;
        res    = bcd_saida;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    carregar     = 1'b0;
    valor        = '0;
    apagar_zeros = 1'b0;
    repeat (3) @(negedge clock);
    vetores++;
    if (bcd_saida !== 20'hFFFFF) begin erros++; $display("FAIL reset_bcd got %h want fffff", bcd_saida); end
    vetores++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      erros++; $display("FAIL reset_flags got ocupado=%b pronto=%b want 0 0", ocupado, pronto);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basico();
    int c, o; logic [19:0] r;
    converter(16'd1234, 1'b1, c, o, r);
    vetores++;
    if (c !== 17) begin erros++; $display("FAIL lat_1234 got %0d want 17", c); end
    vetores++;
    if (o !== 17) begin erros++; $display("FAIL ocupado_1234 got %0d want 17", o); end
    vetores++;
    if (r !== 20'hF1234) begin erros++; $display("FAIL val_1234 got %h want f1234", r); end
    @(negedge clock);
    vetores++;
    if (pronto !== 1'b0 || ocupado !== 1'b0) begin
      erros++; $display("FAIL after_1234 got pronto=%b ocupado=%b want 0 0", pronto, ocupado);
    end
  endtask

  task automatic test_zero();
    int c, o; logic [19:0] r;
    converter(16'd0, 1'b1, c, o, r);
    vetores++;
    if (r !== 20'hFFFF0) begin erros++; $display("FAIL zero_blank got %h want ffff0", r); end
    converter(16'd0, 1'b0, c, o, r);
    vetores++;
    if (r !== 20'h00000) begin erros++; $display("FAIL zero_noblank got %h want 00000", r); end
  endtask

  task automatic test_maximo();
    int c, o; logic [19:0] r;
    converter(16'd65535, 1'b1, c, o, r);
    vetores++;
    if (r !== 20'h65535) begin erros++; $display("FAIL val_65535 got %h want 65535", r); end
    vetores++;
    if (c !== 17) begin erros++; $display("FAIL lat_65535 got %0d want 17", c); end
    converter(16'd42, 1'b0, c, o, r);
    vetores++;
    if (r !== 20'h00042) begin erros++; $display("FAIL val_42 got %h want 00042", r); end
  endtask

  task automatic test_ignora_carregar();
    int np, tp;
    logic [19:0] r;
    np = 0; tp = -1; r = 'x;
    @(negedge clock);
    valor = 16'd9999; apagar_zeros = 1'b1; carregar = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      carregar = 1'b0;
      if (c == 5 || c == 16) begin carregar = 1'b1; valor = 16'd1; end
      if (c == 16) begin
        vetores++;
        if (bcd_saida !== 20'h00042) begin erros++; $display("FAIL hold_c16 got %h want 00042", bcd_saida); end
      end
      if (pronto) begin
        np++;
        if (tp < 0) begin tp = c - 1; r = bcd_saida; end
      end
    end
    carregar = 1'b0;
    vetores++;
    if (np !== 1) begin erros++; $display("FAIL single_pronto got %0d want 1", np); end
    vetores++;
    if (tp !== 17) begin erros++; $display("FAIL lat_9999 got %0d want 17", tp); end
    vetores++;
    if (r !== 20'hF9999) begin erros++; $display("FAIL val_9999 got %h want f9999", r); end
  endtask

  task automatic test_reset_meio();
    int np, c, o;
    logic [19:0] r;
    np = 0;
    @(negedge clock);
    valor = 16'd500; apagar_zeros = 1'b1; carregar = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      carregar = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    vetores++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      erros++; $display("FAIL midreset_flags got ocupado=%b pronto=%b want 0 0", ocupado, pronto);
    end
    vetores++;
    if (bcd_saida !== 20'hFFFFF) begin erros++; $display("FAIL midreset_bcd got %h want fffff", bcd_saida); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (pronto || ocupado) np++;
    end
    vetores++;
    if (np !== 0) begin erros++; $display("FAIL midreset_stale got %0d active cycles want 0", np); end
    converter(16'd7, 1'b1, c, o, r);
    vetores++;
    if (r !== 20'hFFFF7) begin erros++; $display("FAIL val_7 got %h want ffff7", r); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] esperado [3];
    logic [15:0] valores [3];
    int n, ultimo;
    esperado = '{20'hFFF10, 20'hFFF20, 20'hFFF30};
    valores  = '{16'd10, 16'd20, 16'd30};
    n = 0; ultimo = 0;
    @(negedge clock);
    valor = valores[0]; apagar_zeros = 1'b1; carregar = 1'b1;
    for (int c = 1; c <= 80 && n < 3; c++) begin
      @(negedge clock);
      if (pronto) begin
        vetores++;
        if (c - ultimo !== 18) begin erros++; $display("FAIL b2b_period%0d got %0d want 18", n, c - ultimo); end
        vetores++;
        if (bcd_saida !== esperado[n]) begin
          erros++; $display("FAIL b2b_val%0d got %h want %h", n, bcd_saida, esperado[n]);
        end
        ultimo = c;
        n++;
        if (n < 3) valor = valores[n];
        else carregar = 1'b0;
        @(negedge clock);
        c++;
        vetores++;
        if (pronto !== 1'b0) begin erros++; $display("FAIL b2b_pulse%0d got pronto=1 want 0", n); end
      end
    end
    carregar = 1'b0;
    vetores++;
    if (n !== 3) begin erros++; $display("FAIL b2b_count got %0d want 3", n); end
  endtask

  initial begin
    vetores = 0;
    erros   = 0;
    test_reset();
    test_basico();
    test_zero();
    test_maximo();
    test_ignora_carregar();
    test_reset_meio();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
